class_select_ctrl: RTL and testbench

CLASS_SELECT_CTRL -- requirements
Module: class_select_ctrl

---
 rtl/class_select_ctrl_pkg.sv | 20 ++
 rtl/class_select_ctrl_score_cmp.sv | 27 ++
 rtl/class_select_ctrl.sv | 99 +++++++++
 tb/tb_class_select_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/class_select_ctrl_pkg.sv
// Shared constants and FSM encoding for the class-select controller.
package class_select_ctrl_pkg;

    // Default score width and number of classes per inference.
    localparam int NUM_SIZE_DEF    = 26;
    localparam int NUM_CLASSES_DEF = 10;

    // Width of the class index / score counter (supports up to 15 classes).
    localparam int IDX_W = 4;

    // Index value presented after reset, before any inference has run.
    localparam logic [IDX_W-1:0] INDEX_RESET = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/class_select_ctrl_score_cmp.sv
// Signed compare-and-select: keeps the larger of candidate and running max.
// Ties keep the running (lower) index; load_first forces the candidate in.
module score_cmp
    import class_select_ctrl_pkg::*;
#(
    parameter int NUM_SIZE = NUM_SIZE_DEF
) (
    input  logic                       load_first,
    input  logic signed [NUM_SIZE-1:0] cand,
    input  logic signed [NUM_SIZE-1:0] run_max,
    input  logic        [IDX_W-1:0]    cand_idx,
    input  logic        [IDX_W-1:0]    run_idx,
    output logic signed [NUM_SIZE-1:0] new_max,
    output logic        [IDX_W-1:0]    new_idx
);

    // Strictly-greater replaces; first score of an inference always loads.
    always_comb begin
        new_max = run_max;
        new_idx = run_idx;
        if (load_first || (cand > run_max)) begin
            new_max = cand;
            new_idx = cand_idx;
        end
    end

endmodule

// File: rtl/class_select_ctrl.sv
// Collects one inference's class scores and reports the argmax class index.
module class_select_ctrl
    import class_select_ctrl_pkg::*;
#(
    parameter int NUM_SIZE    = NUM_SIZE_DEF,
    parameter int NUM_CLASSES = NUM_CLASSES_DEF
) (
    input  logic                Clk,
    input  logic                GlobalReset,
    input  logic                Start,
    input  logic                ScoreValid,
    input  logic [NUM_SIZE-1:0] ScoreData,
    output logic                ScoreReady,
    output logic                Busy,
    output logic [IDX_W-1:0]    Index,
    output logic                IndexValid,
    input  logic                IndexAck
);

    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NUM_CLASSES - 1);

    state_t                     state_q, state_d;
    logic        [IDX_W-1:0]    cnt_q, cnt_d;
    logic signed [NUM_SIZE-1:0] max_q, max_d;
    logic        [IDX_W-1:0]    idx_q, idx_d;

    logic signed [NUM_SIZE-1:0] cmp_max;
    logic        [IDX_W-1:0]    cmp_idx;
    logic                       accept;

    assign accept = (state_q == ST_COLLECT) && ScoreValid;

    score_cmp #(
        .NUM_SIZE (NUM_SIZE)
    ) u_score_cmp (
        .load_first (cnt_q == '0),
        .cand       ($signed(ScoreData)),
        .run_max    (max_q),
        .cand_idx   (cnt_q),
        .run_idx    (idx_q),
        .new_max    (cmp_max),
        .new_idx    (cmp_idx)
    );

    // Next-state logic: hold everything by default, advance on start/accept/ack.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_COLLECT;
                    cnt_d   = '0;
                end
            end
            ST_COLLECT: begin
                if (accept) begin
                    max_d = cmp_max;
                    idx_d = cmp_idx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (IndexAck) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset wins over every other input.
    always_ff @(posedge Clk) begin
        if (GlobalReset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            max_q   <= '0;
            idx_q   <= INDEX_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
        end
    end

    assign ScoreReady = (state_q == ST_COLLECT);
    assign IndexValid = (state_q == ST_DONE);
    assign Busy       = (state_q != ST_IDLE);
    assign Index      = idx_q;

endmodule

// File: tb/tb_class_select_ctrl.sv
// Directed testbench for class_select_ctrl.
module tb_class_select_ctrl;

    localparam int NS = 26;
    localparam int NC = 10;

    logic          Clk = 1'b0;
    logic          GlobalReset = 1'b0;
    logic          Start = 1'b0;
    logic          ScoreValid = 1'b0;
    logic [NS-1:0] ScoreData = '0;
    logic          ScoreReady;
    logic          Busy;
    logic [3:0]    Index;
    logic          IndexValid;
    logic          IndexAck = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int scores [NC];

    class_select_ctrl #(.NUM_SIZE(NS), .NUM_CLASSES(NC)) dut (
        .Clk         (Clk),
        .GlobalReset (GlobalReset),
        .Start       (Start),
        .ScoreValid  (ScoreValid),
        .ScoreData   (ScoreData),
        .ScoreReady  (ScoreReady),
        .Busy        (Busy),
        .Index       (Index),
        .IndexValid  (IndexValid),
        .IndexAck    (IndexAck)
    );

    always #5 Clk = ~Clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    // Present scores[first..last], each preceded by 'gap' idle cycles.
    task automatic feed(input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) begin
            for (int g = 0; g < gap; g++) begin
                ScoreValid = 1'b0;
                tick();
            end
            ScoreValid = 1'b1;
            ScoreData  = NS'(scores[i]);
            tick();
        end
        ScoreValid = 1'b0;
    endtask

    task automatic do_ack();
        IndexAck = 1'b1;
        tick();
        IndexAck = 1'b0;
    endtask

    task automatic test_reset();
        GlobalReset = 1'b1;
        Start       = 1'b1;   // reset must dominate Start
        tick();
        tick();
        Start       = 1'b0;
        GlobalReset = 1'b0;
        n_cmp++;
        if (Index !== 4'hF) begin n_bad++; $display("FAIL reset_index got=%h exp=F", Index); end
        n_cmp++;
        if ({Busy, ScoreReady, IndexValid} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags got=%b exp=000", {Busy, ScoreReady, IndexValid});
        end
        tick();
        n_cmp++;
        if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle got=%b exp=0", Busy); end
        $display("test_reset: Index=%h Busy=%b", Index, Busy);
    endtask

    task automatic test_basic();
        scores = '{5, -3, 7, 2, 7, 0, 1, -8, 6, 4};
        do_start();
        n_cmp++;
        if ({Busy, ScoreReady, IndexValid} !== 3'b110) begin
            n_bad++; $display("FAIL basic_collect got=%b exp=110", {Busy, ScoreReady, IndexValid});
        end
        feed(0, 8, 0);
        n_cmp++;
        if (IndexValid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid got=%b exp=0", IndexValid); end
        feed(9, 9, 0);
        n_cmp++;
        if (IndexValid !== 1'b1 || ScoreReady !== 1'b0) begin
            n_bad++; $display("FAIL basic_latency valid=%b ready=%b exp 1/0", IndexValid, ScoreReady);
        end
        n_cmp++;
        if (Index !== 4'd2) begin n_bad++; $display("FAIL basic_index got=%0d exp=2", Index); end
        do_ack();
        n_cmp++;
        if (Busy !== 1'b0 || IndexValid !== 1'b0 || Index !== 4'd2) begin
            n_bad++; $display("FAIL basic_ack busy=%b valid=%b idx=%0d exp 0/0/2", Busy, IndexValid, Index);
        end
        $display("test_basic: Index=%0d", Index);
    endtask

    task automatic test_ties();
        for (int i = 0; i < NC; i++) scores[i] = -100;
        do_start();
        feed(0, NC-1, 0);
        n_cmp++;
        if (Index !== 4'd0 || IndexValid !== 1'b1) begin
            n_bad++; $display("FAIL ties_index got=%0d valid=%b exp=0/1", Index, IndexValid);
        end
        do_ack();
        $display("test_ties: Index=%0d", Index);
    endtask

    task automatic test_extremes();
        int minv;
        minv = -(1 << (NS-1));
        for (int i = 0; i < NC; i++) scores[i] = minv;
        scores[9] = minv + 1;
        do_start();
        feed(0, NC-1, 0);
        n_cmp++;
        if (Index !== 4'd9) begin n_bad++; $display("FAIL extreme_index got=%0d exp=9", Index); end
        do_ack();
        $display("test_extremes: Index=%0d", Index);
    endtask

    task automatic test_gapped();
        scores = '{5, -3, 7, 2, 7, 0, 1, -8, 6, 4};
        do_start();
        feed(0, 3, 2);
        ScoreValid = 1'b0;
        tick();
        n_cmp++;
        if (ScoreReady !== 1'b1 || IndexValid !== 1'b0) begin
            n_bad++; $display("FAIL gap_stall ready=%b valid=%b exp 1/0", ScoreReady, IndexValid);
        end
        feed(4, 9, 2);
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (Index !== 4'd2 || IndexValid !== 1'b1) begin
                n_bad++; $display("FAIL gap_hold cyc=%0d idx=%0d valid=%b exp 2/1", c, Index, IndexValid);
            end
            tick();
        end
        do_ack();
        n_cmp++;
        if (Busy !== 1'b0 || IndexValid !== 1'b0) begin
            n_bad++; $display("FAIL gap_idle busy=%b valid=%b exp 0/0", Busy, IndexValid);
        end
        $display("test_gapped: Index=%0d", Index);
    endtask

    task automatic test_reset_mid();
        scores = '{5, -3, 7, 2, 7, 0, 1, -8, 6, 4};
        do_start();
        feed(0, 3, 0);
        GlobalReset = 1'b1;
        ScoreValid  = 1'b1;
        tick();
        GlobalReset = 1'b0;
        ScoreValid  = 1'b0;
        n_cmp++;
        if (Busy !== 1'b0 || ScoreReady !== 1'b0 || Index !== 4'hF) begin
            n_bad++; $display("FAIL midreset busy=%b ready=%b idx=%h exp 0/0/F", Busy, ScoreReady, Index);
        end
        scores = '{-50, -40, -30, -60, -70, -35, -10, -11, -10, -90};
        do_start();
        feed(0, NC-1, 0);
        n_cmp++;
        if (Index !== 4'd6 || IndexValid !== 1'b1) begin
            n_bad++; $display("FAIL midreset_rerun idx=%0d valid=%b exp 6/1", Index, IndexValid);
        end
        do_ack();
        $display("test_reset_mid: Index=%0d", Index);
    endtask

    task automatic test_ignored();
        // ScoreValid in IDLE: no effect
        ScoreValid = 1'b1;
        ScoreData  = NS'(1000);
        tick();
        tick();
        ScoreValid = 1'b0;
        n_cmp++;
        if (Busy !== 1'b0 || Index !== 4'd6) begin
            n_bad++; $display("FAIL ign_idle busy=%b idx=%0d exp 0/6", Busy, Index);
        end
        // Start held high during COLLECT must not restart the counter
        scores = '{1, 2, 3, 4, 5, 6, 7, 9, 8, 0};
        do_start();
        Start = 1'b1;
        feed(0, NC-1, 1);
        n_cmp++;
        if (Index !== 4'd7 || IndexValid !== 1'b1) begin
            n_bad++; $display("FAIL ign_collect idx=%0d valid=%b exp 7/1", Index, IndexValid);
        end
        // Start and ScoreValid in DONE: no effect
        ScoreValid = 1'b1;
        ScoreData  = NS'(5000);
        tick();
        tick();
        tick();
        ScoreValid = 1'b0;
        Start      = 1'b0;
        n_cmp++;
        if (Index !== 4'd7 || IndexValid !== 1'b1 || ScoreReady !== 1'b0) begin
            n_bad++; $display("FAIL ign_done idx=%0d valid=%b ready=%b exp 7/1/0", Index, IndexValid, ScoreReady);
        end
        do_ack();
        $display("test_ignored: Index=%0d", Index);
    endtask

    task automatic test_back_to_back();
        scores = '{3, 3, 3, 3, 3, 3, 3, 3, 4, 3};
        do_start();
        feed(0, NC-1, 0);
        do_ack();
        scores = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10};
        do_start();
        n_cmp++;
        if (Index !== 4'd8) begin n_bad++; $display("FAIL b2b_hold idx=%0d exp=8", Index); end
        feed(0, NC-1, 0);
        n_cmp++;
        if (Index !== 4'd0 || IndexValid !== 1'b1) begin
            n_bad++; $display("FAIL b2b_second idx=%0d valid=%b exp 0/1", Index, IndexValid);
        end
        do_ack();
        $display("test_back_to_back: Index=%0d", Index);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_extremes();
        test_gapped();
        test_reset_mid();
        test_ignored();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
